lsu_ctrl: RTL and testbench

- Load/store unit between the core's memory stage and the word-addressed data_mem.
- Takes byte-addressed RV32I load/store requests and drives the memory's single word port.
- Aligns and sign/zero-extends load data.
- Has no byte enables, so it performs read-modify-write for SB/SH.
- Flags misaligned, out-of-range and illegal-funct3 accesses without touching memory.

---
 rtl/lsu_pkg.sv | 36 +++
 rtl/lsu_align.sv | 41 ++++
 rtl/lsu_ctrl.sv | 138 +++++++++++++
 tb/tb_lsu_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit: funct3 codes, FSM states,
// and the access legality checks applied at request acceptance.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WAIT,
        WR
    } lsu_state_e;

    // size is funct3[1:0]: 0=byte, 1=half, 2=word.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b01:   misaligned = off[0];
            2'b10:   misaligned = (off != 2'b00);
            default: misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
        if (we) begin
            funct3_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        end else begin
            funct3_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                           (funct3 == F3_BU) || (funct3 == F3_HU);
        end
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts/extends load data from a memory word and
// merges sub-word store data into the old word for read-modify-write.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] ld_data,
    output logic [31:0] st_word
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign lane_b = word[{off, 3'b000} +: 8];
    assign lane_h = word[{off[1], 4'b0000} +: 16];

    always_comb begin
        case (funct3)
            F3_B:    ld_data = {{24{lane_b[7]}}, lane_b};
            F3_H:    ld_data = {{16{lane_h[15]}}, lane_h};
            F3_W:    ld_data = word;
            F3_BU:   ld_data = {24'h0, lane_b};
            F3_HU:   ld_data = {16'h0, lane_h};
            default: ld_data = 32'h0;
        endcase
    end

    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
        st_word = word;
        case (funct3[1:0])
            2'b00:   st_word[{off, 3'b000} +: 8]     = wdata[7:0];
            2'b01:   st_word[{off[1], 4'b0000} +: 16] = wdata[15:0];
            default: st_word = wdata;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// RV32I load/store unit driving a single-port, word-addressed, registered-read
// data memory; sub-word stores are done as read-modify-write.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int N  = 1024,
    parameter int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [2:0]    req_funct3,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    output logic [31:0]   resp_rdata,
    output logic          resp_err,
    output logic [AW-1:0] mem_a,
    output logic [31:0]   mem_wd,
    output logic          mem_we,
    input  logic [31:0]   mem_rd
);

    lsu_state_e    state_q, state_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [2:0]    f3_q, f3_d;
    logic          we_q, we_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   merged_q, merged_d;
    logic          err_pend_q, err_pend_d;
    logic          resp_valid_q, resp_valid_d;
    logic          resp_err_q, resp_err_d;
    logic [31:0]   resp_rdata_q, resp_rdata_d;

    logic          req_err;
    logic [31:0]   ld_data;
    logic [31:0]   st_word;

    assign req_err = !funct3_legal(req_we, req_funct3) ||
                     misaligned(req_funct3[1:0], req_addr[1:0]) ||
                     ({2'b00, req_addr[31:2]} >= 32'(N));

    lsu_align u_align (
        .word    (mem_rd),
        .wdata   (wdata_q),
        .off     (addr_q[1:0]),
        .funct3  (f3_q),
        .ld_data (ld_data),
        .st_word (st_word)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        f3_d         = f3_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        merged_d     = merged_q;
        err_pend_d   = 1'b0;
        // A rejected request answers one edge after acceptance while the FSM stays idle.
        resp_valid_d = err_pend_q;
        resp_err_d   = err_pend_q;
        resp_rdata_d = 32'h0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d   = req_addr[AW+1:0];
                    f3_d     = req_funct3;
                    we_d     = req_we;
                    wdata_d  = req_wdata;
                    merged_d = req_wdata;
                    if (req_err) begin
                        err_pend_d = 1'b1;
                    end else if (req_we && (req_funct3 == F3_W)) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD:   state_d = WAIT;
            WAIT: begin
                if (we_q) begin
                    merged_d = st_word;
                    state_d  = WR;
                end else begin
                    resp_valid_d = 1'b1;
                    resp_rdata_d = ld_data;
                    state_d      = IDLE;
                end
            end
            WR: begin
                resp_valid_d = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            f3_q         <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            merged_q     <= '0;
            err_pend_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            f3_q         <= f3_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            merged_q     <= merged_d;
            err_pend_q   <= err_pend_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    // Memory controls decode straight from state so reset drops mem_we immediately.
    assign req_ready  = (state_q == IDLE);
    assign mem_we     = (state_q == WR);
    assign mem_a      = ((state_q == RD) || (state_q == WR)) ? addr_q[AW+1:2] : '0;
    assign mem_wd     = (state_q == WR) ? merged_q : '0;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: a behavioural data_mem plus a per-edge
// expectation model derived from the access rules, compared every cycle.
module tb_lsu_ctrl;

    localparam int N  = 1024;
    localparam int AW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [2:0]    req_funct3 = 3'b000;
    logic [31:0]   req_addr = 32'h0;
    logic [31:0]   req_wdata = 32'h0;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic [AW-1:0] mem_a;
    logic [31:0]   mem_wd;
    logic          mem_we;
    logic [31:0]   mem_rd;

    lsu_ctrl #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_we     (mem_we),
        .mem_rd     (mem_rd)
    );

    always #5 clk = ~clk;

    // data_mem: synchronous write, registered read.
    logic [31:0] mem     [N];
    logic [31:0] ref_mem [N];
    always @(posedge clk) begin
        if (mem_we) mem[mem_a] <= mem_wd;
        mem_rd <= mem[mem_a];
    end

    int edge_n;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_n <= 0;
        else        edge_n <= edge_n + 1;
    end

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_on   = 1'b0;
    int ready_after = 0;

    // Expectations keyed by edge index: value seen in the cycle after that edge.
    bit          busy   [int];
    bit          exp_rv [int];
    logic [31:0] exp_rd [int];
    bit          exp_re [int];
    bit          exp_we [int];
    int          exp_ma [int];
    logic [31:0] exp_wd [int];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic wait_edge();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] off,
                                             input logic [2:0] f3);
        logic [31:0] b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'd128)   ? b - 32'd256   : b;
            3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'd2:    return w;
            3'd4:    return b;
            3'd5:    return h;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [1:0] off, input logic [2:0] f3);
        logic [31:0] mask, val;
        if (f3[1:0] == 2'd0) begin
            mask = 32'hFF << (8 * off);
            val  = (wd & 32'hFF) << (8 * off);
        end else begin
            mask = 32'hFFFF << (16 * (off / 2));
            val  = (wd & 32'hFFFF) << (16 * (off / 2));
        end
        return (old & ~mask) | val;
    endfunction

    // Presents a request (optionally while the unit is still busy), waits for the edge
    // at which it must be accepted, and records every expected bus/response cycle.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input int early,
                          output logic [31:0] exp_d, output logic exp_err);
        int acc, start, k, lat, wi, sz;
        logic legal;
        logic [31:0] nv;
        acc = (ready_after + 1 > edge_n + 1) ? ready_after + 1 : edge_n + 1;
        start = acc - 1 - early;
        if (start < edge_n) start = edge_n;
        while (edge_n < start) wait_edge();
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        while (edge_n < acc) wait_edge();
        req_valid = 1'b0;
        k = acc;

        sz      = 1 << f3[1:0];
        legal   = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        exp_err = !legal || ((addr % sz) != 0) || (addr >= 32'(4 * N));
        exp_d   = 32'h0;
        wi      = int'(addr >> 2);
        if (exp_err) begin
            lat = 1;
        end else if (!we) begin
            lat = 2;
            exp_d = load_ext(ref_mem[wi], addr[1:0], f3);
            exp_ma[k] = wi;
        end else if (f3[1:0] == 2'd2) begin
            lat = 1;
            ref_mem[wi] = wd;
            exp_we[k] = 1'b1;
            exp_ma[k] = wi;
            exp_wd[k] = wd;
        end else begin
            lat = 3;
            nv = store_merge(ref_mem[wi], wd, addr[1:0], f3);
            ref_mem[wi] = nv;
            exp_ma[k]     = wi;
            exp_we[k + 2] = 1'b1;
            exp_ma[k + 2] = wi;
            exp_wd[k + 2] = nv;
        end
        exp_rv[k + lat] = 1'b1;
        exp_rd[k + lat] = exp_d;
        exp_re[k + lat] = exp_err;
        if (exp_err) begin
            ready_after = k;
        end else begin
            for (int e = k; e < k + lat; e++) busy[e] = 1'b1;
            ready_after = k + lat;
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            int e;
            e = edge_n;
            check("req_ready", {31'b0, req_ready}, busy.exists(e) ? 32'd0 : 32'd1);
            check("resp_valid", {31'b0, resp_valid}, exp_rv.exists(e) ? 32'd1 : 32'd0);
            if (exp_rv.exists(e)) begin
                check("resp_rdata", resp_rdata, exp_rd[e]);
                check("resp_err", {31'b0, resp_err}, {31'b0, exp_re[e]});
            end
            check("mem_we", {31'b0, mem_we}, exp_we.exists(e) ? 32'd1 : 32'd0);
            check("mem_a", 32'(mem_a), exp_ma.exists(e) ? 32'(exp_ma[e]) : 32'd0);
            check("mem_wd", mem_wd, exp_wd.exists(e) ? exp_wd[e] : 32'd0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, v, a;
        logic        er, we;
        logic [2:0]  f3;
        int          r, early;

        for (int i = 0; i < N; i++) begin
            v = $urandom;
            mem[i]     <= v;
            ref_mem[i]  = v;
        end

        repeat (3) @(posedge clk);
        #1;
        check("rst resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst resp_err", {31'b0, resp_err}, 32'd0);
        check("rst resp_rdata", resp_rdata, 32'd0);
        check("rst mem_we", {31'b0, mem_we}, 32'd0);
        check("rst mem_a", 32'(mem_a), 32'd0);
        check("rst mem_wd", mem_wd, 32'd0);
        check("rst req_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk) rst_n = 1'b1;
        wait_edge();

        // Reset while an SB sits in WAIT: nothing may be written.
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h20; req_wdata = 32'h55;
        wait_edge();
        req_valid = 1'b0;
        check("rmw rd mem_a", 32'(mem_a), 32'd8);
        check("rmw rd mem_we", {31'b0, mem_we}, 32'd0);
        wait_edge();
        check("rmw wait mem_we", {31'b0, mem_we}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst async mem_we", {31'b0, mem_we}, 32'd0);
        check("rst async resp_valid", {31'b0, resp_valid}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("rst hold mem_we", {31'b0, mem_we}, 32'd0);
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("post rst req_ready", {31'b0, req_ready}, 32'd1);
            check("post rst resp_valid", {31'b0, resp_valid}, 32'd0);
            check("post rst mem_we", {31'b0, mem_we}, 32'd0);
        end
        check("rst word unchanged", mem[8], ref_mem[8]);

        wait_edge();
        ready_after = edge_n;
        cmp_on = 1'b1;

        // Word round trip and back-to-back loads.
        do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, d, er);
        check("sw err", {31'b0, er}, 32'd0);
        do_req(1'b1, 3'd2, 32'h14, 32'h0BADF00D, 0, d, er);
        do_req(0, 3'd2, 32'h10, 32'h0, 0, d, er);
        check("lw model", d, 32'hDEADBEEF);
        do_req(0, 3'd2, 32'h14, 32'h0, 0, d, er);
        check("lw b2b model", d, 32'h0BADF00D);

        // Sign/zero extension on 0x80FF7F01.
        do_req(1'b1, 3'd2, 32'h10, 32'h80FF7F01, 1, d, er);
        do_req(0, 3'd0, 32'h11, 32'h0, 0, d, er);
        check("lb 0x11", d, 32'h0000007F);
        do_req(0, 3'd0, 32'h13, 32'h0, 2, d, er);
        check("lb 0x13", d, 32'hFFFFFF80);
        do_req(0, 3'd4, 32'h13, 32'h0, 0, d, er);
        check("lbu 0x13", d, 32'h00000080);
        do_req(0, 3'd1, 32'h12, 32'h0, 0, d, er);
        check("lh 0x12", d, 32'hFFFF80FF);
        do_req(0, 3'd5, 32'h12, 32'h0, 0, d, er);
        check("lhu 0x12", d, 32'h000080FF);

        // Sub-word read-modify-write.
        do_req(1'b1, 3'd2, 32'h10, 32'h11223344, 0, d, er);
        do_req(1'b1, 3'd0, 32'h12, 32'h000000AA, 2, d, er);
        check("sb merge model", ref_mem[4], 32'h11AA3344);
        do_req(1'b1, 3'd1, 32'h10, 32'h0000BEEF, 0, d, er);
        check("sh merge model", ref_mem[4], 32'h11AABEEF);
        do_req(0, 3'd2, 32'h10, 32'h0, 0, d, er);

        // Rejected accesses, including back-to-back errors, and the top legal word.
        do_req(0, 3'd1, 32'h11, 32'h0, 0, d, er);
        check("lh misaligned err", {31'b0, er}, 32'd1);
        do_req(1'b1, 3'd2, 32'h12, 32'h12345678, 0, d, er);
        check("sw misaligned err", {31'b0, er}, 32'd1);
        do_req(0, 3'd3, 32'h10, 32'h0, 0, d, er);
        check("funct3 011 err", {31'b0, er}, 32'd1);
        do_req(0, 3'd2, 32'(4 * N), 32'h0, 0, d, er);
        check("lw 4N err", {31'b0, er}, 32'd1);
        do_req(1'b1, 3'd4, 32'h10, 32'h0, 0, d, er);
        do_req(0, 3'd2, 32'hFFFFFFFC, 32'h0, 0, d, er);
        do_req(1'b1, 3'd2, 32'(4 * N - 4), 32'hCAFEF00D, 0, d, er);
        check("top word legal", {31'b0, er}, 32'd0);
        do_req(0, 3'd2, 32'(4 * N - 4), 32'h0, 0, d, er);
        check("top word model", d, 32'hCAFEF00D);
        check("mem word 4 written", mem[4], 32'h11AABEEF);

        // Randomized traffic over a small hot region plus the range boundary.
        for (int i = 0; i < 400; i++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            r  = $urandom_range(0, 9);
            if (r < 7)       a = 32'($urandom_range(0, 15)) << 2;
            else if (r == 7) a = 32'(N - 1) << 2;
            else if (r == 8) a = 32'(N + $urandom_range(0, 3)) << 2;
            else             a = $urandom & 32'hFFFFFFFC;
            if ($urandom_range(0, 9) < 6) a = a | (32'($urandom_range(0, 3)) & ~((32'd1 << f3[1:0]) - 1) & 32'd3);
            else                          a = a | 32'($urandom_range(0, 3));
            early = $urandom_range(0, 3);
            do_req(we, f3, a, $urandom, early, d, er);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) wait_edge();
        end

        repeat (6) wait_edge();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
